program_counter_fetch: RTL and testbench

- Instruction-fetch front end of the processor.
- Holds the 12-bit program counter that drives the program ROM address bus and captures the 8-bit ROM output into a fetch register.
- Splits the captured byte into instruction and operand nibbles for the decoder.
- Runs a two-phase FETCH/EXECUTE sequence, with absolute jump load and wrap-around handling.

---
 rtl/program_counter_fetch.sv | 111 +++++++++++
 tb/tb_program_counter_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/program_counter_fetch.sv
// Instruction-fetch front end: program counter, fetch register and FETCH/EXECUTE sequencer.
// Define PC_WRAP_HALT_EN to halt on a FETCH increment past the top address instead of wrapping.
module program_counter_fetch #(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 12'h000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [ADDR_W-1:0]   direccion,
    output logic [DATA_W-1:0]   program_byte,
    output logic [DATA_W/2-1:0] instr,
    output logic [DATA_W/2-1:0] oprnd,
    output logic                phase,
    output logic                valid,
    output logic                halted
);

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   byte_q, byte_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic                at_top_s;

    assign at_top_s = (pc_q == {ADDR_W{1'b1}});

    // Next-state logic for the sequencer, program counter and fetch register
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        if (enable && !halted_q) begin
            case (state_q)
                FETCH: begin
                    byte_d  = rom_data;
                    valid_d = 1'b1;
                    state_d = EXECUTE;
                    if (load) begin
                        pc_d = load_addr;
                    end else begin
`ifdef PC_WRAP_HALT_EN
                        // Stop at the top of the address space rather than wrapping to zero
                        if (at_top_s) begin
                            halted_d = 1'b1;
                            pc_d     = pc_q;
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
`else
                        pc_d = pc_q + ADDR_W'(1);
`endif
                    end
                end
                EXECUTE: begin
                    state_d = FETCH;
                    if (load) begin
                        pc_d = load_addr;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end else begin
            state_d = state_q;
        end
`ifndef PC_WRAP_HALT_EN
        halted_d = 1'b0;
`endif
    end

    // State registers with synchronous reset taking priority over everything else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_ADDR;
            byte_q   <= {DATA_W{1'b0}};
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign direccion    = pc_q;
    assign program_byte = byte_q;
    assign instr        = byte_q[DATA_W-1:DATA_W/2];
    assign oprnd        = byte_q[DATA_W/2-1:0];
    assign phase        = state_q;
    assign valid        = valid_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_program_counter_fetch.sv
// Directed, table-driven bench for program_counter_fetch with a behavioural ROM.
// Expectations for the wrap case follow PC_WRAP_HALT_EN when it is defined.
module tb_program_counter_fetch;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [11:0] load_addr;
    logic [7:0]  rom_data;
    logic [11:0] direccion;
    logic [7:0]  program_byte;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        phase;
    logic        valid;
    logic        halted;

    logic [7:0]  rom [0:4095];

    int errors = 0;
    int checks = 0;

    program_counter_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .load_addr    (load_addr),
        .rom_data     (rom_data),
        .direccion    (direccion),
        .program_byte (program_byte),
        .instr        (instr),
        .oprnd        (oprnd),
        .phase        (phase),
        .valid        (valid),
        .halted       (halted)
    );

    assign rom_data = rom[direccion];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        ld;
        logic [11:0] la;
        logic [11:0] e_pc;
        logic [7:0]  e_byte;
        logic        e_ph;
        logic        e_v;
        logic        e_h;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [0:NV-1];

    function automatic vec_t mk(input logic rst, input logic en, input logic ld,
                                input logic [11:0] la, input logic [11:0] e_pc,
                                input logic [7:0] e_byte, input logic e_ph,
                                input logic e_v, input logic e_h);
        vec_t v;
        v.rst = rst; v.en = en; v.ld = ld; v.la = la;
        v.e_pc = e_pc; v.e_byte = e_byte; v.e_ph = e_ph; v.e_v = e_v; v.e_h = e_h;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic ld, input logic [11:0] la);
        reset = rst; enable = en; load = ld; load_addr = la;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic [11:0] e_pc, input logic [7:0] e_byte,
                             input logic e_ph, input logic e_v, input logic e_h);
        logic [7:0] eb;
        eb = e_byte;
        check($sformatf("v%0d direccion", idx), direccion, e_pc);
        check($sformatf("v%0d program_byte", idx), {4'h0, program_byte}, {4'h0, eb});
        check($sformatf("v%0d instr", idx), {8'h00, instr}, {8'h00, eb[7:4]});
        check($sformatf("v%0d oprnd", idx), {8'h00, oprnd}, {8'h00, eb[3:0]});
        check($sformatf("v%0d phase", idx), {11'h000, phase}, {11'h000, e_ph});
        check($sformatf("v%0d valid", idx), {11'h000, valid}, {11'h000, e_v});
        check($sformatf("v%0d halted", idx), {11'h000, halted}, {11'h000, e_h});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'hA5;
        rom[12'h001] = 8'h3C;
        rom[12'h002] = 8'h11;
        rom[12'h003] = 8'h22;
        rom[12'h0FE] = 8'h71;
        rom[12'h0FF] = 8'h82;
        rom[12'h100] = 8'h93;
        rom[12'h123] = 8'h6B;
        rom[12'h7F0] = 8'h5E;
        rom[12'h7F1] = 8'hC3;
        rom[12'h7F2] = 8'h47;
        rom[12'hFFF] = 8'h9D;

        reset = 1'b1; enable = 1'b0; load = 1'b0; load_addr = 12'h000;

        //                rst   en    ld    la       pc       byte   ph    v     h
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h001, 8'hA5, 1'b1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h001, 8'hA5, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h002, 8'h3C, 1'b1, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h002, 8'h3C, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h003, 8'h11, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b1, 12'h7F0, 12'h7F0, 8'h11, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h7F1, 8'h5E, 1'b1, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 12'h0AA, 12'h7F1, 8'h5E, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 12'h0AA, 12'h7F1, 8'h5E, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 12'h0AA, 12'h7F1, 8'h5E, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 12'h0AA, 12'h7F1, 8'h5E, 1'b1, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 12'h0AA, 12'h7F1, 8'h5E, 1'b1, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h7F1, 8'h5E, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h7F2, 8'hC3, 1'b1, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 12'h7F2, 12'h7F2, 8'hC3, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b1, 12'h123, 12'h123, 8'h47, 1'b1, 1'b1, 1'b0);
        vecs[17] = mk(1'b1, 1'b1, 1'b1, 12'h555, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h001, 8'hA5, 1'b1, 1'b1, 1'b0);
        vecs[19] = mk(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, 1'b1, 12'hFFF, 12'hFFF, 8'hA5, 1'b1, 1'b1, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'hFFF, 8'hA5, 1'b0, 1'b1, 1'b0);
`ifdef PC_WRAP_HALT_EN
        vecs[22] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'hFFF, 8'h9D, 1'b1, 1'b1, 1'b1);
        vecs[23] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'hFFF, 8'h9D, 1'b1, 1'b1, 1'b1);
        vecs[24] = mk(1'b0, 1'b1, 1'b1, 12'h100, 12'hFFF, 8'h9D, 1'b1, 1'b1, 1'b1);
`else
        vecs[22] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 8'h9D, 1'b1, 1'b1, 1'b0);
        vecs[23] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 8'h9D, 1'b0, 1'b1, 1'b0);
        vecs[24] = mk(1'b0, 1'b1, 1'b1, 12'h100, 12'h100, 8'hA5, 1'b1, 1'b1, 1'b0);
`endif
        vecs[25] = mk(1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[26] = mk(1'b0, 1'b1, 1'b1, 12'hFFF, 12'hFFF, 8'hA5, 1'b1, 1'b1, 1'b0);
        vecs[27] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'hFFF, 8'hA5, 1'b0, 1'b1, 1'b0);
        vecs[28] = mk(1'b0, 1'b1, 1'b1, 12'h010, 12'h010, 8'h9D, 1'b1, 1'b1, 1'b0);

        #2;
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].la);
            check_all(i, vecs[i].e_pc, vecs[i].e_byte, vecs[i].e_ph, vecs[i].e_v, vecs[i].e_h);
        end

        // Carry out of the low byte: jump to 0FE and run through 0FF into 100
        step(1'b1, 1'b0, 1'b0, 12'h000);
        check_all(100, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 12'h0FE);
        check_all(101, 12'h0FE, 8'hA5, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        check_all(102, 12'h0FE, 8'hA5, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        check_all(103, 12'h0FF, 8'h71, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        check_all(104, 12'h0FF, 8'h71, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        check_all(105, 12'h100, 8'h82, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        check_all(106, 12'h101, 8'h93, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
